// File: rtl/bcd_sched_pkg.sv
// Shared types and helpers for the time-shared binary-to-BCD converter.
// The add-3 correction is sized by DEF_BCD_DIGITS so other BCD logic can reuse it.
package bcd_sched_pkg;

   localparam int DEF_NUM_W      = 8;
   localparam int DEF_BCD_DIGITS = 3;
   localparam int BCD_W          = DEF_BCD_DIGITS * 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      WRITE = 2'd3
   } state_e;

   // One double-dabble correction step: every digit of five or more gets +3.
   function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] bcd);
      logic [BCD_W-1:0] res;
      res = bcd;
      for (int d = 0; d < DEF_BCD_DIGITS; d++) begin
         if (res[d*4 +: 4] >= 4'd5) begin
            res[d*4 +: 4] = res[d*4 +: 4] + 4'd3;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/bcd_rr_arbiter.sv
// Picks the next dirty channel for the shared converter.
// BCD_SCHED_FIXED_PRIO_EN selects fixed priority (lowest index wins) instead of round-robin.
module bcd_rr_arbiter
   import bcd_sched_pkg::*;
#(
   parameter int NUM_REQ = 3
) (
   input  logic [NUM_REQ-1:0] dirty_i,
   input  logic [1:0]         rr_ptr_i,
   output logic [1:0]         grant_o,
   output logic               any_dirty_o
);

   assign any_dirty_o = |dirty_i;

`ifdef BCD_SCHED_FIXED_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^rr_ptr_i;

   // Scanning downward leaves the lowest dirty index as the final winner.
   always_comb begin
      grant_o = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (dirty_i[i]) begin
            grant_o = 2'(i);
         end
      end
   end
`else
   logic found;
   int   idx;

   // Search starts one past the last served channel and wraps.
   always_comb begin
      grant_o = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(rr_ptr_i) + k) % NUM_REQ;
         if (!found && dirty_i[idx]) begin
            grant_o = 2'(idx);
            found   = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/bcd_convert_scheduler.sv
// Shares one shift-add-3 binary-to-BCD engine among NUM_REQ sources, reconverting only changed inputs.
// Define BCD_SCHED_FIXED_PRIO_EN for fixed-priority arbitration; default is round-robin.
module bcd_convert_scheduler
   import bcd_sched_pkg::*;
#(
   parameter int NUM_W      = DEF_NUM_W,
   parameter int BCD_DIGITS = DEF_BCD_DIGITS,
   parameter int NUM_REQ    = 3
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_REQ*NUM_W-1:0]      num_in,
   output logic [NUM_REQ*BCD_DIGITS*4-1:0] bcd_out,
   output logic [NUM_REQ-1:0]            bcd_valid,
   output logic                          busy,
   output logic [1:0]                    cur_sel
);

   localparam int SHIFT_W = BCD_DIGITS * 4 + NUM_W;
   localparam int ITER_W  = $clog2(NUM_W + 1);

   state_e                          state_q, state_d;
   logic [NUM_REQ*NUM_W-1:0]        snap_q;
   logic [SHIFT_W-1:0]              shift_q;
   logic [ITER_W-1:0]               iter_q;
   logic [1:0]                      sel_q;
   logic [NUM_REQ*BCD_DIGITS*4-1:0] bcd_q;
   logic [NUM_REQ-1:0]              valid_q;
   logic [NUM_REQ-1:0]              dirty;
   logic [1:0]                      rrPtr;
   logic [1:0]                      grant;
   logic                            anyDirty;
   logic [SHIFT_W-1:0]              shiftAdj;

   // A channel needs work until it has a result and whenever its input leaves the snapshot.
   always_comb begin
      dirty = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         dirty[i] = !valid_q[i] || (num_in[i*NUM_W +: NUM_W] != snap_q[i*NUM_W +: NUM_W]);
      end
   end

`ifdef BCD_SCHED_FIXED_PRIO_EN
   assign rrPtr = 2'd0;
`else
   logic [1:0] rr_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_q <= 2'(NUM_REQ - 1);
      end else if (state_q == WRITE) begin
         rr_q <= sel_q;
      end
   end

   assign rrPtr = rr_q;
`endif

   bcd_rr_arbiter #(
      .NUM_REQ(NUM_REQ)
   ) u_arbiter (
      .dirty_i    (dirty),
      .rr_ptr_i   (rrPtr),
      .grant_o    (grant),
      .any_dirty_o(anyDirty)
   );

   assign shiftAdj = {add3_digits(shift_q[SHIFT_W-1 -: BCD_W]), shift_q[NUM_W-1:0]};

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (anyDirty) state_d = LOAD;
         LOAD:    state_d = SHIFT;
         SHIFT:   if (iter_q == ITER_W'(NUM_W - 1)) state_d = WRITE;
         WRITE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // The grant is latched in IDLE so cur_sel is already stable for the whole conversion.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         snap_q  <= '0;
         shift_q <= '0;
         iter_q  <= '0;
         sel_q   <= '0;
         bcd_q   <= '0;
         valid_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (anyDirty) sel_q <= grant;
            end
            LOAD: begin
               snap_q[sel_q*NUM_W +: NUM_W] <= num_in[sel_q*NUM_W +: NUM_W];
               shift_q <= {{(BCD_DIGITS*4){1'b0}}, num_in[sel_q*NUM_W +: NUM_W]};
               iter_q  <= '0;
            end
            SHIFT: begin
               shift_q <= {shiftAdj[SHIFT_W-2:0], 1'b0};
               iter_q  <= iter_q + ITER_W'(1);
            end
            WRITE: begin
               bcd_q[sel_q*BCD_W +: BCD_W] <= shift_q[SHIFT_W-1 -: BCD_W];
               valid_q[sel_q]              <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bcd_out   = bcd_q;
   assign bcd_valid = valid_q;
   assign busy      = (state_q != IDLE);
   assign cur_sel   = sel_q;

endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// Self-checking bench for bcd_convert_scheduler: vector table, scoreboard of expected
// writes per channel, and hand-written timing / reset / arbitration sequences.
module tb_bcd_convert_scheduler;

   localparam int NUM_W      = 8;
   localparam int BCD_DIGITS = 3;
   localparam int NUM_REQ    = 3;

   typedef struct {
      int         ch;
      logic [11:0] bcd;
   } exp_t;

   typedef struct {
      int          ch;
      logic [7:0]  value;
      logic [11:0] expBcd;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [23:0] numIn;
   logic [35:0] bcdOut;
   logic [2:0]  bcdValid;
   logic        busy;
   logic [1:0]  curSel;

   int assertCount = 0;
   int failCount   = 0;

   exp_t       expQ[$];
   logic [1:0] grantLog[$];

   logic [35:0] prevBcd   = '0;
   logic [2:0]  prevValid = '0;
   logic        prevBusy  = 1'b0;

   vec_t vectors[7];

   // 100 MHz clock
   always #5 clk = ~clk;

   bcd_convert_scheduler #(
      .NUM_W     (NUM_W),
      .BCD_DIGITS(BCD_DIGITS),
      .NUM_REQ   (NUM_REQ)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .num_in   (numIn),
      .bcd_out  (bcdOut),
      .bcd_valid(bcdValid),
      .busy     (busy),
      .cur_sel  (curSel)
   );

   // Golden decimal split, computed arithmetically rather than by shift-add-3
   function automatic logic [11:0] toBcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // Every comparison in the bench goes through here
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // Drive one channel; a real change means exactly one future write of expBcd
   task automatic applyStimulus(input int ch, input logic [7:0] value, input logic [11:0] expBcd);
      exp_t e;
      if (numIn[ch*8 +: 8] != value) begin
         e.ch  = ch;
         e.bcd = expBcd;
         expQ.push_back(e);
      end
      numIn[ch*8 +: 8] = value;
   endtask

   // Match an observed write against the oldest pending expectation for that channel
   task automatic popAndCheck(input int ch, input logic [11:0] actual);
      int idx;
      idx = -1;
      for (int i = 0; i < expQ.size(); i++) begin
         if (idx < 0 && expQ[i].ch == ch) idx = i;
      end
      if (idx < 0) begin
         assertCount++;
         failCount++;
         $display("[TB] FAIL unexpected write ch%0d: actual=%0h expected=no write", ch, actual);
      end else begin
         checkOutput($sformatf("write ch%0d", ch), actual, expQ[idx].bcd);
         expQ.delete(idx);
      end
   endtask

   // Wait (bounded) until the engine has been idle for two consecutive samples
   task automatic waitIdle(input int budget);
      int idleRun;
      idleRun = 0;
      for (int n = 0; n < budget && idleRun < 2; n++) begin
         @(negedge clk);
         if (!busy) idleRun++;
         else idleRun = 0;
      end
      checkOutput("idle reached", idleRun >= 2, 1);
   endtask

   // Compare the first three recorded grants against an expected order
   task automatic checkGrants(input string name, input logic [1:0] g0, input logic [1:0] g1, input logic [1:0] g2);
      logic [1:0] expOrder[3];
      expOrder[0] = g0;
      expOrder[1] = g1;
      expOrder[2] = g2;
      checkOutput({name, " count"}, grantLog.size(), 3);
      for (int i = 0; i < 3; i++) begin
         if (grantLog.size() > 0) begin
            checkOutput($sformatf("%s[%0d]", name, i), grantLog.pop_front(), expOrder[i]);
         end
      end
   endtask

   // Monitor: any change of a channel's BCD field or rise of its valid is a write;
   // each rise of busy records which channel was granted
   always @(negedge clk) begin
      if (!reset_n) begin
         prevBcd   <= '0;
         prevValid <= '0;
         prevBusy  <= 1'b0;
      end else begin
         for (int ch = 0; ch < NUM_REQ; ch++) begin
            if ((bcdValid[ch] && !prevValid[ch]) || (bcdOut[ch*12 +: 12] != prevBcd[ch*12 +: 12])) begin
               popAndCheck(ch, bcdOut[ch*12 +: 12]);
            end
         end
         if (busy && !prevBusy) grantLog.push_back(curSel);
         prevBcd   <= bcdOut;
         prevValid <= bcdValid;
         prevBusy  <= busy;
      end
   end

   // Hang guard
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus sequence
   initial begin
      vectors[0] = '{0, 8'd128, 12'h128};
      vectors[1] = '{1, 8'd9,   12'h009};
      vectors[2] = '{1, 8'd10,  12'h010};
      vectors[3] = '{2, 8'd199, 12'h199};
      vectors[4] = '{0, 8'd100, 12'h100};
      vectors[5] = '{1, 8'd250, 12'h250};
      vectors[6] = '{2, 8'd1,   12'h001};

      // Reset state
      reset_n = 1'b0;
      numIn   = {8'd7, 8'd42, 8'd255};
      repeat (3) @(negedge clk);
      checkOutput("reset bcd_out", bcdOut, 36'h0);
      checkOutput("reset bcd_valid", bcdValid, 3'b000);
      checkOutput("reset busy", busy, 1'b0);
      checkOutput("reset cur_sel", curSel, 2'd0);

      // Initial conversion of all three channels after release
      $display("[TB] initial conversion after reset");
      expQ.push_back('{0, 12'h255});
      expQ.push_back('{1, 12'h042});
      expQ.push_back('{2, 12'h007});
      reset_n = 1'b1;
      repeat (32) @(negedge clk);
      checkOutput("valid before last write", bcdValid, 3'b011);
      @(negedge clk);
      checkOutput("valid after last write", bcdValid, 3'b111);
      checkOutput("busy after initial", busy, 1'b0);
      checkOutput("initial bcd_out", bcdOut, {12'h007, 12'h042, 12'h255});
      waitIdle(20);
      checkGrants("initial grants", 2'd0, 2'd1, 2'd0 + 2'd2);

      // Table-driven single-channel updates
      $display("[TB] vector table");
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vectors[i].ch, vectors[i].value, vectors[i].expBcd);
         waitIdle(60);
         checkOutput($sformatf("table[%0d]", i), bcdOut[vectors[i].ch*12 +: 12], vectors[i].expBcd);
      end

      // Exact latency of a single update on channel 2
      $display("[TB] latency of ch2 update");
      applyStimulus(2, 8'd2, 12'h002);
      @(negedge clk);
      checkOutput("latency busy", busy, 1'b1);
      checkOutput("latency cur_sel", curSel, 2'd2);
      repeat (9) @(negedge clk);
      checkOutput("ch2 held before write", bcdOut[35:24], 12'h001);
      @(negedge clk);
      checkOutput("ch2 after write", bcdOut[35:24], 12'h002);
      waitIdle(40);
      checkOutput("ch0 untouched", bcdOut[11:0], 12'h100);
      checkOutput("ch1 untouched", bcdOut[23:12], 12'h250);

      // Input change during the 3rd SHIFT cycle of a ch0 conversion
      $display("[TB] change mid-conversion");
      applyStimulus(0, 8'd50, 12'h050);
      repeat (4) @(negedge clk);
      checkOutput("mid busy", busy, 1'b1);
      checkOutput("mid cur_sel", curSel, 2'd0);
      applyStimulus(0, 8'd99, 12'h099);
      waitIdle(80);
      checkOutput("ch0 final", bcdOut[11:0], 12'h099);

      // All three dirty together with the pointer on channel 0
      $display("[TB] simultaneous dirty channels");
      grantLog.delete();
      applyStimulus(0, 8'd11, 12'h011);
      applyStimulus(1, 8'd22, 12'h022);
      applyStimulus(2, 8'd33, 12'h033);
      waitIdle(120);
`ifdef BCD_SCHED_FIXED_PRIO_EN
      checkGrants("simultaneous grants", 2'd0, 2'd1, 2'd2);
`else
      checkGrants("simultaneous grants", 2'd1, 2'd2, 2'd0);
`endif
      checkOutput("simultaneous bcd_out", bcdOut, {12'h033, 12'h022, 12'h011});

      // Asynchronous reset in the middle of a conversion
      $display("[TB] reset mid-conversion");
      applyStimulus(0, 8'd0, 12'h000);
      applyStimulus(1, 8'd200, 12'h200);
      applyStimulus(2, 8'd0, 12'h000);
      repeat (5) @(negedge clk);
      checkOutput("pre-reset busy", busy, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("async reset bcd_out", bcdOut, 36'h0);
      checkOutput("async reset valid", bcdValid, 3'b000);
      checkOutput("async reset busy", busy, 1'b0);
      checkOutput("async reset cur_sel", curSel, 2'd0);
      expQ.delete();
      @(negedge clk);
      @(negedge clk);
      grantLog.delete();
      expQ.push_back('{0, 12'h000});
      expQ.push_back('{1, 12'h200});
      expQ.push_back('{2, 12'h000});
      reset_n = 1'b1;
      waitIdle(120);
      checkOutput("post-reset valid", bcdValid, 3'b111);
      checkOutput("post-reset bcd_out", bcdOut, {12'h000, 12'h200, 12'h000});
      checkGrants("post-reset grants", 2'd0, 2'd1, 2'd2);

      // Full sweep of channel 1 against the arithmetic model
      $display("[TB] sweep ch1 0..255");
      for (int v = 0; v < 256; v++) begin
         applyStimulus(1, 8'(v), toBcd(v));
         waitIdle(40);
      end
      checkOutput("sweep final ch1", bcdOut[23:12], 12'h255);
      checkOutput("sweep ch0 untouched", bcdOut[11:0], 12'h000);

      checkOutput("scoreboard drained", expQ.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
